// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side and WB-side handshake plus payload bundle for mem_wb_stage
interface mem_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CTRL_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_W-1:0]  out_rs;
  logic [REG_W-1:0]  out_rd;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_mem_data;
  modport master (
    output in_valid, in_ctrl, in_rs, in_rd, in_data, in_mem_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rs, out_rd, out_data, out_mem_data
  );
  modport slave (
    input  in_valid, in_ctrl, in_rs, in_rd, in_data, in_mem_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_rs, out_rd, out_data, out_mem_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB stage register with valid/ready, flush and saturating stall counter; MEM_WB_SKID_EN adds a skid entry and registers in_ready
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  mem_wb_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_count
);
  localparam int PW = CTRL_W + 2*REG_W + 2*DATA_W;
  logic [PW-1:0] in_p, main_q, main_d;
  logic          main_v, main_v_d, in_fire, out_fire;
  assign in_p     = {bus.in_ctrl, bus.in_rs, bus.in_rd, bus.in_data, bus.in_mem_data};
  assign {bus.out_ctrl, bus.out_rs, bus.out_rd, bus.out_data, bus.out_mem_data} = main_q;
  assign bus.out_valid = main_v;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = main_v && bus.out_ready;
`ifdef MEM_WB_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          skid_v, skid_v_d;
  assign bus.in_ready = !skid_v;
  // in_ready is low whenever skid is valid, so no input can arrive in that branch
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v;
    skid_d   = skid_q;
    skid_v_d = skid_v;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v) begin
      if (out_fire) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (in_fire && (!main_v || bus.out_ready)) begin
      main_d   = in_p;
      main_v_d = 1'b1;
    end else if (in_fire) begin
      skid_d   = in_p;
      skid_v_d = 1'b1;
    end else if (out_fire) begin
      main_v_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_q <= '0;
      skid_v <= 1'b0;
    end else begin
      skid_q <= skid_d;
      skid_v <= skid_v_d;
    end
  end
`else
  assign bus.in_ready = !main_v || bus.out_ready;
  always_comb begin
    main_v_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : main_v;
    main_d   = (in_fire && !flush) ? in_p : main_q;
  end
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q <= '0;
      main_v <= 1'b0;
    end else begin
      main_q <= main_d;
      main_v <= main_v_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset)
      stall_count <= '0;
    else if (main_v && !bus.out_ready && !flush && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage; a 4-bit stall counter exposes saturation
module tb_mem_wb_stage;
  localparam int DW = 16, RW = 3, CW = 3, NW = 4;
  localparam int PW = CW + 2*RW + 2*DW;
  logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [NW-1:0] stall_count;
  int checks = 0, fails = 0;
  logic [PW-1:0] exp_q[$];
  mem_wb_stage_if #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW)) b();
  mem_wb_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(b), .stall_count(stall_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [PW-1:0] pay(input logic [DW-1:0] d, input logic [RW-1:0] r);
    return {r ^ 3'b101, ~r, r, d, ~d};
  endfunction
  task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r);
    int n = 0;
    b.in_valid = 1'b1; b.in_data = d; b.in_rd = r; b.in_rs = ~r;
    b.in_ctrl = r ^ 3'b101; b.in_mem_data = ~d;
    while (!b.in_ready && n < 20) begin step(); n++; end
    chk("send_ready", b.in_ready, 1);
    if (b.in_ready) exp_q.push_back(pay(d, r));
    step();
    b.in_valid = 1'b0;
  endtask
  always @(negedge clock) begin
    if (!reset && !flush && b.out_valid && b.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got data %0h expected no output", b.out_data);
      end else begin
        logic [PW-1:0] e, a;
        e = exp_q.pop_front();
        a = {b.out_ctrl, b.out_rs, b.out_rd, b.out_data, b.out_mem_data};
        if (a !== e) begin
          fails++;
          $display("FAIL mon_payload: got %0h expected %0h", a, e);
        end
      end
    end
  end
  initial begin
    b.in_valid = 1'b0; b.out_ready = 1'b0; b.in_ctrl = '0; b.in_rs = '0;
    b.in_rd = '0; b.in_data = '0; b.in_mem_data = '0;
    repeat (2) begin
      b.in_valid = 1'($urandom); b.out_ready = 1'($urandom);
      b.in_data = 16'($urandom); b.in_mem_data = 16'($urandom);
      b.in_rd = 3'($urandom); b.in_rs = 3'($urandom); b.in_ctrl = 3'($urandom);
      step();
    end
    chk("rst_valid", b.out_valid, 0);
    chk("rst_payload", {b.out_ctrl, b.out_rs, b.out_rd, b.out_data, b.out_mem_data}, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_in_ready", b.in_ready, 1);
    reset = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(16'(i), 3'(i));
      chk("stream_valid", b.out_valid, 1);
      chk("stream_data", b.out_data, i);
    end
    step();
    chk("stream_drained", b.out_valid, 0);
    chk("stream_stall", stall_count, 0);
    b.out_ready = 1'b0;
    send(16'h00A5, 3'd5);
    chk("bp_stall0", stall_count, 0);
`ifdef MEM_WB_SKID_EN
    send(16'hBEEF, 3'd6);
`else
    step();
`endif
    chk("bp_stall1", stall_count, 1);
    chk("bp_hold", b.out_data, 16'h00A5);
    chk("bp_in_ready", b.in_ready, 0);
    repeat (4) begin
      step();
      chk("bp_hold", b.out_data, 16'h00A5);
      chk("bp_in_ready", b.in_ready, 0);
    end
    chk("bp_stall5", stall_count, 5);
    b.out_ready = 1'b1;
    repeat (3) step();
    chk("bp_stall_kept", stall_count, 5);
    chk("bp_drained", exp_q.size(), 0);
    b.out_ready = 1'b0;
    send(16'h0B0B, 3'd1);
`ifdef MEM_WB_SKID_EN
    send(16'h0C0C, 3'd2);
`else
    step();
`endif
    chk("fl_stall_pre", stall_count, 6);
    flush = 1'b1; b.in_valid = 1'b1; b.in_data = 16'h1234;
    chk("fl_in_ready", b.in_ready, 0);
    step();
    exp_q.delete();
    chk("fl_valid", b.out_valid, 0);
    chk("fl_stall_same", stall_count, 6);
    flush = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
    repeat (2) step();
    chk("fl_stays_empty", b.out_valid, 0);
    flush = 1'b1; b.in_valid = 1'b1; b.in_data = 16'h1234;
    chk("fl2_in_ready", b.in_ready, 1);
    step();
    flush = 1'b0; b.in_valid = 1'b0;
    chk("fl2_discard", b.out_valid, 0);
    step();
    chk("fl2_still_empty", b.out_valid, 0);
    b.out_ready = 1'b0;
    send(16'h0D0D, 3'd3);
`ifdef MEM_WB_SKID_EN
    send(16'h0E0E, 3'd4);
`else
    step();
`endif
    chk("rs_stall_pre", stall_count, 7);
    reset = 1'b1; b.in_valid = 1'b1; b.in_data = 16'h5555;
    step();
    reset = 1'b0; b.in_valid = 1'b0;
    exp_q.delete();
    chk("rs_valid", b.out_valid, 0);
    chk("rs_payload", {b.out_ctrl, b.out_rs, b.out_rd, b.out_data, b.out_mem_data}, 0);
    chk("rs_stall", stall_count, 0);
    chk("rs_in_ready", b.in_ready, 1);
    send(16'h0F0F, 3'd7);
    repeat (20) step();
    chk("sat_15", stall_count, 15);
    step();
    chk("sat_hold", stall_count, 15);
    b.out_ready = 1'b1;
    repeat (3) step();
    chk("end_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
